result_drain_streamer: RTL

//  Downstream stage of the 10x10 systolic array. On the array's done rising edge, snapshots the

---
 rtl/npu_pkg.sv | 16 +
 rtl/result_requant.sv | 37 +++
 rtl/result_drain_streamer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared types and dimensions for the systolic-array result drain path.
package npu_pkg;

  localparam int unsigned N     = 10;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned NN    = N * N;
  localparam int unsigned IDX_W = $clog2(NN);

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  typedef logic signed [IN_W-1:0] elem_t;

endpackage

// File: rtl/result_requant.sv
// Combinational requantizer: arithmetic shift, optional ReLU, saturate to OUT_W.
module result_requant #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic        [OUT_W-1:0] out_o,
  output logic                    clip_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(1 << (OUT_W - 1)));

  logic signed [IN_W-1:0] sh;
  logic                   hi;
  logic                   lo;

  always_comb begin
    sh = in_i >>> SHIFT;
    if (RELU_EN && sh[IN_W-1]) begin
      sh = '0;
    end
    hi     = (sh > MAX_V);
    lo     = (sh < MIN_V);
    clip_o = hi | lo;
    if (hi) begin
      out_o = OUT_W'(MAX_V);
    end else if (lo) begin
      out_o = OUT_W'(MIN_V);
    end else begin
      out_o = sh[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/result_drain_streamer.sv
// Snapshots the NxN result matrix on done rising edge and streams requantized
// elements row-major over valid/ready, tracking overruns and clipped elements.
module result_drain_streamer
  import npu_pkg::*;
#(
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              done,
  input  logic [N-1:0][N-1:0][IN_W-1:0]     A_result,
  input  logic                              clr,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [OUT_W-1:0]                  m_data,
  output logic [3:0]                        m_row,
  output logic [3:0]                        m_col,
  output logic                              m_last,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              overrun,
  output logic [6:0]                        sat_count
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [3:0]       POS_MAX  = 4'(N - 1);

  drain_state_t     state_q, state_d;
  logic             done_q;
  elem_t            mat_q [N][N];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       row_q, row_d, col_q, col_d;
  logic             valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic             fd_q, fd_d, ovr_q, ovr_d;
  logic [OUT_W-1:0] data_q;
  logic             clip_q;
  logic [6:0]       sat_q, sat_d;

  logic             rise, hs, capture, ld_out;
  elem_t            rq_in;
  logic [OUT_W-1:0] rq_out;
  logic             rq_clip;

  assign rise = done & ~done_q;
  assign hs   = valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    capture = 1'b0;
    ld_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          capture = 1'b1;
          ld_out  = 1'b1;
          state_d = STREAM;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            fd_d    = 1'b1;
          end else begin
            ld_out = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (col_q == POS_MAX) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            last_d = (idx_d == IDX_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The capture edge writes the buffer, so the first element bypasses it.
    rq_in = capture ? elem_t'(A_result[0][0]) : mat_q[row_d][col_d];

    ovr_d = ovr_q;
    if (rise && busy_q) begin
      ovr_d = 1'b1;
    end else if (clr) begin
      ovr_d = 1'b0;
    end

    sat_d = sat_q;
    if (hs && clip_q) begin
      if (sat_q != '1) begin
        sat_d = sat_q + 1'b1;
      end
    end else if (clr) begin
      sat_d = '0;
    end
  end

  result_requant #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .RELU_EN(RELU_EN)
  ) u_requant (
    .in_i  (rq_in),
    .out_o (rq_out),
    .clip_o(rq_clip)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          mat_q[r][c] <= A_result[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      clip_q  <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
      sat_q   <= sat_d;
      if (ld_out) begin
        data_q <= rq_out;
        clip_q <= rq_clip;
      end
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_row      = row_q;
  assign m_col      = col_q;
  assign m_last     = last_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;
  assign sat_count  = sat_q;

endmodule
